// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// One shift-add (multiply) or restoring-divide step per cycle on operand
// magnitudes. Signs are re-applied in a dedicated fix-up cycle.
// Divide by zero short-circuits from LOAD straight to DONE.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] Port_A,
   input  logic [WIDTH-1:0] Port_B,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int DW    = 2 * WIDTH;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_CALC = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Two's-complement negation of a WIDTH-bit value.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return (~v) + WIDTH'(1'b1);
   endfunction

   // Two's-complement negation of a 2*WIDTH-bit value.
   function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v);
      return (~v) + DW'(1'b1);
   endfunction

   // Magnitude of v; only treated as signed when sgn is set.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic sgn);
      logic [WIDTH-1:0] r;
      if (sgn && v[WIDTH-1]) begin
         r = neg_w(v);
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Architectural and control state
   state_t             state_r;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               neg_res_r;
   logic               neg_rem_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               busy_r;
   logic               done_r;
   logic               dbz_r;

   // Working registers: acc_r is the product accumulator for multiply and
   // holds dividend/quotient in its low half for divide; opd_r is the
   // multiplicand or the divisor magnitude; rem_r the partial remainder.
   logic [DW-1:0]      acc_r;
   logic [WIDTH-1:0]   opd_r;
   logic [WIDTH:0]     rem_r;

   // Combinational helpers
   logic               is_div_s;
   logic               is_signed_s;
   logic               sgn_a_s;
   logic               sgn_b_s;
   logic [WIDTH-1:0]   mag_a_s;
   logic [WIDTH-1:0]   mag_b_s;
   logic               dbz_s;
   logic [WIDTH:0]     add_hi_s;
   logic [WIDTH+1:0]   shift_s;
   logic [WIDTH:0]     diff_s;
   logic [DW-1:0]      calc_acc_s;
   logic [WIDTH:0]     calc_rem_s;
   logic [DW-1:0]      prod_fix_s;
   logic [WIDTH-1:0]   quo_fix_s;
   logic [WIDTH-1:0]   rem_fix_s;

   assign busy        = busy_r;
   assign done        = done_r;
   assign hi          = hi_r;
   assign lo          = lo_r;
   assign div_by_zero = dbz_r;

   // Operand decode, magnitudes and divide-by-zero detection on latched operands
   always_comb begin
      is_div_s    = op_r[1];
      is_signed_s = ~op_r[0];
      sgn_a_s     = is_signed_s & a_r[WIDTH-1];
      sgn_b_s     = is_signed_s & b_r[WIDTH-1];
      mag_a_s     = abs_val(a_r, is_signed_s);
      mag_b_s     = abs_val(b_r, is_signed_s);
      if (is_div_s && (b_r == {WIDTH{1'b0}})) begin
         dbz_s = 1'b1;
      end else begin
         dbz_s = 1'b0;
      end
   end

   // One iteration step: shift-add multiply or restoring divide
   always_comb begin
      add_hi_s   = {(WIDTH+1){1'b0}};
      shift_s    = {(WIDTH+2){1'b0}};
      diff_s     = {(WIDTH+1){1'b0}};
      calc_acc_s = acc_r;
      calc_rem_s = rem_r;
      if (is_div_s) begin
         // Bring in the next dividend bit, try subtracting the divisor.
         shift_s = {rem_r, acc_r[WIDTH-1]};
         diff_s  = shift_s[WIDTH:0] - {1'b0, opd_r};
         if (shift_s >= {2'b00, opd_r}) begin
            calc_rem_s = diff_s;
            calc_acc_s = {acc_r[DW-1:WIDTH], acc_r[WIDTH-2:0], 1'b1};
         end else begin
            calc_rem_s = shift_s[WIDTH:0];
            calc_acc_s = {acc_r[DW-1:WIDTH], acc_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         // Add multiplicand into the upper half when the low bit is set,
         // then shift the whole accumulator right by one (carry kept).
         if (acc_r[0]) begin
            add_hi_s = {1'b0, acc_r[DW-1:WIDTH]} + {1'b0, opd_r};
         end else begin
            add_hi_s = {1'b0, acc_r[DW-1:WIDTH]};
         end
         calc_acc_s = {add_hi_s, acc_r[WIDTH-1:1]};
         calc_rem_s = rem_r;
      end
   end

   // Sign fix-up of the finished magnitude result
   always_comb begin
      if (neg_res_r) begin
         prod_fix_s = neg_dw(acc_r);
         quo_fix_s  = neg_w(acc_r[WIDTH-1:0]);
      end else begin
         prod_fix_s = acc_r;
         quo_fix_s  = acc_r[WIDTH-1:0];
      end
      if (neg_rem_r) begin
         rem_fix_s = neg_w(rem_r[WIDTH-1:0]);
      end else begin
         rem_fix_s = rem_r[WIDTH-1:0];
      end
   end

   // Control FSM with registered busy/done/flag and HI/LO result registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r   <= S_IDLE;
         op_r      <= 2'b00;
         a_r       <= {WIDTH{1'b0}};
         b_r       <= {WIDTH{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
         acc_r     <= {DW{1'b0}};
         opd_r     <= {WIDTH{1'b0}};
         rem_r     <= {(WIDTH+1){1'b0}};
         hi_r      <= {WIDTH{1'b0}};
         lo_r      <= {WIDTH{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         dbz_r     <= 1'b0;
      end else if (state_r == S_IDLE) begin
         // Accept a new request; flush in the same cycle drops it.
         if (start && !flush) begin
            state_r <= S_LOAD;
            op_r    <= op;
            a_r     <= Port_A;
            b_r     <= Port_B;
            dbz_r   <= 1'b0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
         end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
         end
      end else if (flush) begin
         // Abort: results and flag keep their previous values, no done.
         state_r <= S_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            S_LOAD: begin
               neg_res_r <= sgn_a_s ^ sgn_b_s;
               neg_rem_r <= sgn_a_s;
               cnt_r     <= CNT_W'(WIDTH);
               rem_r     <= {(WIDTH+1){1'b0}};
               if (dbz_s) begin
                  state_r <= S_DONE;
                  hi_r    <= a_r;
                  lo_r    <= {WIDTH{1'b1}};
                  dbz_r   <= 1'b1;
                  done_r  <= 1'b1;
               end else if (is_div_s) begin
                  state_r <= S_CALC;
                  opd_r   <= mag_b_s;
                  acc_r   <= {{WIDTH{1'b0}}, mag_a_s};
                  done_r  <= 1'b0;
               end else begin
                  state_r <= S_CALC;
                  opd_r   <= mag_a_s;
                  acc_r   <= {{WIDTH{1'b0}}, mag_b_s};
                  done_r  <= 1'b0;
               end
            end
            S_CALC: begin
               acc_r <= calc_acc_s;
               rem_r <= calc_rem_s;
               cnt_r <= cnt_r - CNT_W'(1'b1);
               if (cnt_r == CNT_W'(1'b1)) begin
                  state_r <= S_FIX;
               end else begin
                  state_r <= S_CALC;
               end
            end
            S_FIX: begin
               if (is_div_s) begin
                  hi_r <= rem_fix_s;
                  lo_r <= quo_fix_s;
               end else begin
                  hi_r <= prod_fix_s[DW-1:WIDTH];
                  lo_r <= prod_fix_s[WIDTH-1:0];
               end
               state_r <= S_DONE;
               done_r  <= 1'b1;
            end
            S_DONE: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed MIPS mult/div results,
// latency, divide-by-zero, flush, ignored start, async reset, WIDTH=8 build.
module tb_muldiv_unit;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        start;
   logic [1:0]  op;
   logic [31:0] Port_A;
   logic [31:0] Port_B;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   logic        start8;
   logic [1:0]  op8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        flush8;
   logic        busy8;
   logic        done8;
   logic [7:0]  hi8;
   logic [7:0]  lo8;
   logic        dbz8;

   int total = 0;
   int bad   = 0;

   muldiv_unit #(.WIDTH(32)) u_dut (
      .CLK(CLK), .nRST(nRST), .start(start), .op(op),
      .Port_A(Port_A), .Port_B(Port_B), .flush(flush),
      .busy(busy), .done(done), .hi(hi), .lo(lo),
      .div_by_zero(div_by_zero)
   );

   muldiv_unit #(.WIDTH(8)) u_dut8 (
      .CLK(CLK), .nRST(nRST), .start(start8), .op(op8),
      .Port_A(a8), .Port_B(b8), .flush(flush8),
      .busy(busy8), .done(done8), .hi(hi8), .lo(lo8),
      .div_by_zero(dbz8)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one op at cycle 0; optional flush / stray start at given cycles.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int flush_at,
                         input int start_at, output int lat,
                         output int busy_lo, output logic busy_fl);
      int c;
      @(posedge CLK); #1;
      start = 1'b1; op = o; Port_A = a; Port_B = b; flush = 1'b0;
      c = 0; lat = -1; busy_lo = 0; busy_fl = 1'b1;
      while (c < 60) begin
         @(posedge CLK); #1;
         c++;
         start = 1'b0; flush = 1'b0;
         op = 2'b10; Port_A = 32'hDEAD_BEEF; Port_B = 32'h0000_0000;
         if (c == start_at) begin
            start = 1'b1; op = 2'b01; Port_A = 32'd9; Port_B = 32'd9;
         end
         if (c == flush_at) flush = 1'b1;
         if (c == flush_at + 1) busy_fl = busy;
         if (done) begin
            lat = c;
            break;
         end
         if (!busy) busy_lo++;
      end
      start = 1'b0; flush = 1'b0;
   endtask

   int   lat;
   int   blo;
   logic bfl;

   initial begin
      nRST = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
      Port_A = 32'h0; Port_B = 32'h0;
      start8 = 1'b0; flush8 = 1'b0; op8 = 2'b00; a8 = 8'h00; b8 = 8'h00;
      repeat (2) @(posedge CLK);
      #1;
      check_val("rst_hi",   hi, 32'h0);
      check_val("rst_lo",   lo, 32'h0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_dbz",  32'(div_by_zero), 32'd0);
      nRST = 1'b1;

      // 1: MULTU max*max
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -10, -10, lat, blo, bfl);
      check_val("multu_lat",  32'(lat), 32'd35);
      check_val("multu_busy", 32'(blo), 32'd0);
      check_val("multu_hi",   hi, 32'hFFFF_FFFE);
      check_val("multu_lo",   lo, 32'h0000_0001);

      // 2: MULT signed
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -10, -10, lat, blo, bfl);
      check_val("mult_neg_hi", hi, 32'hFFFF_FFFF);
      check_val("mult_neg_lo", lo, 32'hFFFF_FFEB);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -10, -10, lat, blo, bfl);
      check_val("mult_min_hi", hi, 32'h4000_0000);
      check_val("mult_min_lo", lo, 32'h0000_0000);

      // 3: divides
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -10, -10, lat, blo, bfl);
      check_val("div_lat", 32'(lat), 32'd35);
      check_val("div_lo",  lo, 32'hFFFF_FFFD);
      check_val("div_hi",  hi, 32'hFFFF_FFFF);
      run_op(2'b11, 32'd7, 32'd2, -10, -10, lat, blo, bfl);
      check_val("divu_lo", lo, 32'd3);
      check_val("divu_hi", hi, 32'd1);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -10, -10, lat, blo, bfl);
      check_val("div_ovf_lo", lo, 32'h8000_0000);
      check_val("div_ovf_hi", hi, 32'h0000_0000);
      check_val("div_ovf_dbz", 32'(div_by_zero), 32'd0);

      // 4: divide by zero, then flag cleared by next op
      run_op(2'b11, 32'h0000_1234, 32'h0, -10, -10, lat, blo, bfl);
      check_val("dbz_lat", 32'(lat), 32'd2);
      check_val("dbz_flag", 32'(div_by_zero), 32'd1);
      check_val("dbz_hi", hi, 32'h0000_1234);
      check_val("dbz_lo", lo, 32'hFFFF_FFFF);
      run_op(2'b01, 32'd4, 32'd5, -10, -10, lat, blo, bfl);
      check_val("dbz_clr", 32'(div_by_zero), 32'd0);
      check_val("m45_lo", lo, 32'd20);

      // 5: flush at cycle 10, then stray start at cycle 5 ignored
      run_op(2'b01, 32'd5, 32'd6, 10, -10, lat, blo, bfl);
      check_val("flush_busy", 32'(bfl), 32'd0);
      check_val("flush_nodone", 32'(lat), 32'hFFFF_FFFF);
      check_val("flush_hi", hi, 32'd0);
      check_val("flush_lo", lo, 32'd20);
      run_op(2'b01, 32'd5, 32'd6, -10, 5, lat, blo, bfl);
      check_val("ign_lat", 32'(lat), 32'd35);
      check_val("ign_lo", lo, 32'd30);
      check_val("ign_hi", hi, 32'd0);

      // 6: async reset in the middle of a DIV
      @(posedge CLK); #1;
      start = 1'b1; op = 2'b10; Port_A = 32'd100; Port_B = 32'd7;
      repeat (20) begin
         @(posedge CLK); #1;
         start = 1'b0;
      end
      nRST = 1'b0;
      #1;
      check_val("arst_busy", 32'(busy), 32'd0);
      check_val("arst_hi", hi, 32'd0);
      check_val("arst_lo", lo, 32'd0);
      check_val("arst_done", 32'(done), 32'd0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      run_op(2'b01, 32'd2, 32'd3, -10, -10, lat, blo, bfl);
      check_val("post_rst_lat", 32'(lat), 32'd35);
      check_val("post_rst_lo", lo, 32'd6);
      check_val("post_rst_hi", hi, 32'd0);

      // WIDTH=8 build: 0xFF*0xFF
      @(posedge CLK); #1;
      start8 = 1'b1; op8 = 2'b01; a8 = 8'hFF; b8 = 8'hFF;
      lat = -1;
      for (int c = 1; c < 40; c++) begin
         @(posedge CLK); #1;
         start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
         if (done8) begin
            lat = c;
            break;
         end
      end
      check_val("w8_lat", 32'(lat), 32'd11);
      check_val("w8_hi", 32'(hi8), 32'h0000_00FE);
      check_val("w8_lo", 32'(lo8), 32'h0000_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit that completes the ALU datapath with MIPS MULT/MULTU/DIV/DIVU semantics and architectural HI/LO registers. It is a multi-cycle, handshake-controlled block. It uses one shift-add or restoring-divide step per cycle and is parametrised in operand width. It sits beside the combinational ALU in EX; the hazard unit stalls on busy, and MFHI/MFLO read hi/lo directly.

Parameters:
WIDTH, 32, operand width in bits; hi and lo are each WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
nRST  input  1  asynchronous, active-low reset.
start  input  1  request a new operation; sampled only in IDLE.
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
Port_A  input  WIDTH  multiplicand or dividend; sampled with start.
Port_B  input  WIDTH  multiplier or divisor; sampled with start.
flush  input  1  abort the in-flight operation (branch mispredict or exception).
busy  output  1  high in every state except IDLE.
done  output  1  single-cycle pulse; hi/lo hold the new result in the same cycle.
hi  output  WIDTH  product upper half, or remainder.
lo  output  WIDTH  product lower half, or quotient.
div_by_zero  output  1  high with done when a DIV/DIVU had Port_B == 0; cleared by the next accepted start.

Behaviour:
- Reset (async, nRST=0): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0, working regs=0. Reset mid-operation discards all work.
- States:
  - IDLE -> LOAD on start && !flush.
  - LOAD (1 cycle): capture magnitudes. For signed ops, take |A| and |B|; record neg_result = signA^signB (mult/quotient) and neg_rem = signA. Load counter=WIDTH.
  - CALC: WIDTH cycles, one step per cycle, counter decrements. Leaves to FIX when counter reaches 1 and the step is taken.
  - FIX (1 cycle): conditional two's-complement negation of the 2*WIDTH product, the quotient, and (separately) the remainder. Write hi/lo.
  - DONE (1 cycle): done=1, then -> IDLE.
- Latency: start accepted at cycle 0 -> done high at cycle WIDTH+3 (35 for WIDTH=32). Back-to-back: the next start is accepted in the cycle after done.
- Multiply: shift-add on a 2*WIDTH accumulator. The unsigned core operates on magnitudes. {hi,lo} = full 2*WIDTH product; no overflow flag.
- Divide: restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder. Quotient truncates toward zero. Remainder takes the sign of the dividend.
- Divide by zero: LOAD -> DONE directly, skipping CALC and FIX. hi=Port_A (raw), lo=all ones, div_by_zero=1 with done. Latency is 2 cycles.
- Signed overflow: DIV of the most negative value by -1 gives lo=most negative value, hi=0. This is the natural wrap; no flag.
- start while busy: ignored, with no effect on state or outputs.
- flush in any non-IDLE state: -> IDLE next edge, busy=0. hi/lo/div_by_zero keep their previous values, and no done is issued. flush and start in the same IDLE cycle: flush wins, start is dropped.
- hi/lo change only in FIX, or in DONE via the divide-by-zero path, and hold otherwise.
- Inputs are not required to be stable after the start cycle.

Test Plan:
1. MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> done at cycle 35, hi=0xFFFFFFFE, lo=0x00000001, busy high cycles 1–34.
2. MULT, A=-3 (0xFFFFFFFD), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT with A=0x80000000, B=0x80000000 -> hi=0x40000000, lo=0.
3. DIV, A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, A=7, B=2 -> lo=3, hi=1. DIV, A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU, A=0x1234, B=0 -> done at cycle 2, div_by_zero=1, hi=0x1234, lo=0xFFFFFFFF. The next start clears div_by_zero.
5. Start MULTU 5*6, assert flush at cycle 10 -> busy=0 at cycle 11, no done, hi/lo unchanged. A second start at cycle 5 of a running op is ignored (result still 30).
6. nRST low at cycle 20 of a DIV -> all outputs 0 immediately (async). After release, a new MULTU 2*3 gives lo=6, hi=0. Repeat case 1 with WIDTH=8 (0xFF*0xFF -> hi=0xFE, lo=0x01, done at cycle 11).
